// File: rtl/editor_valores_pkg.sv
// rtl/editor_valores_pkg.sv - shared encodings, states and BCD field limits for editor_valores
// Purpose: mode/position encodings, FSM state type, per-mode per-field BCD
//          limits, reset values, and helpers returning a field's min/max.
// Ports:   none (package).
package editor_pkg;

   localparam logic [1:0] MODE_NONE  = 2'b00;
   localparam logic [1:0] MODE_TIMER = 2'b01;
   localparam logic [1:0] MODE_FECHA = 2'b10;
   localparam logic [1:0] MODE_HORA  = 2'b11;

   localparam logic [1:0] POS_NONE = 2'b00;
   localparam logic [1:0] POS_F0   = 2'b01;
   localparam logic [1:0] POS_F1   = 2'b10;
   localparam logic [1:0] POS_F2   = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_EDIT   = 2'b01,
      ST_COMMIT = 2'b10
   } state_t;

   // hora and timer share limits: hh 00-23, mm/ss 00-59
   localparam logic [7:0] HH_MIN   = 8'h00;
   localparam logic [7:0] HH_MAX   = 8'h23;
   localparam logic [7:0] MS_MIN   = 8'h00;
   localparam logic [7:0] MS_MAX   = 8'h59;
   // fecha: day 01-31 (month length not checked), month 01-12, year 00-99
   localparam logic [7:0] DIA_MIN  = 8'h01;
   localparam logic [7:0] DIA_MAX  = 8'h31;
   localparam logic [7:0] MES_MIN  = 8'h01;
   localparam logic [7:0] MES_MAX  = 8'h12;
   localparam logic [7:0] ANIO_MIN = 8'h00;
   localparam logic [7:0] ANIO_MAX = 8'h99;

   localparam logic [23:0] HORA_RESET  = 24'h000000;
   localparam logic [23:0] FECHA_RESET = 24'h010100;
   localparam logic [23:0] TIMER_RESET = 24'h000000;

   function automatic logic [7:0] field_min(input logic [1:0] mode, input logic [1:0] pos);
      logic [7:0] r;
      r = 8'h00;
      if (mode == MODE_FECHA) begin
         case (pos)
            POS_F0:  r = DIA_MIN;
            POS_F1:  r = MES_MIN;
            default: r = ANIO_MIN;
         endcase
      end else begin
         r = (pos == POS_F0) ? HH_MIN : MS_MIN;
      end
      return r;
   endfunction

   function automatic logic [7:0] field_max(input logic [1:0] mode, input logic [1:0] pos);
      logic [7:0] r;
      r = 8'h00;
      if (mode == MODE_FECHA) begin
         case (pos)
            POS_F0:  r = DIA_MAX;
            POS_F1:  r = MES_MAX;
            default: r = ANIO_MAX;
         endcase
      end else begin
         r = (pos == POS_F0) ? HH_MAX : MS_MAX;
      end
      return r;
   endfunction

endpackage

// File: rtl/editor_valores_bcd_step.sv
// rtl/editor_valores_bcd_step.sv - combinational two-digit BCD increment/decrement with wrap
// Purpose: steps an 8-bit BCD value by +1 or -1, wrapping max->min and min->max.
//          inc and dec together (or neither) leave the value unchanged.
// Ports:   value (in 8)   current BCD value
//          min_val (in 8) lowest legal value
//          max_val (in 8) highest legal value
//          inc, dec (in 1) step direction
//          result (out 8) stepped BCD value
module bcd_step (
   input  logic [7:0] value,
   input  logic [7:0] min_val,
   input  logic [7:0] max_val,
   input  logic       inc,
   input  logic       dec,
   output logic [7:0] result
);

   always_comb begin
      result = value;
      if (inc && !dec) begin
         if (value == max_val)
            result = min_val;
         else if (value[3:0] == 4'h9)
            result = {value[7:4] + 4'h1, 4'h0};
         else
            result = {value[7:4], value[3:0] + 4'h1};
      end else if (dec && !inc) begin
         if (value == min_val)
            result = max_val;
         else if (value[3:0] == 4'h0)
            result = {value[7:4] - 4'h1, 4'h9};
         else
            result = {value[7:4], value[3:0] - 4'h1};
      end
   end

endmodule

// File: rtl/editor_valores.sv
// rtl/editor_valores.sv - BCD time/date/timer field editor with RTC write handshake
// Purpose: mirrors RTC read values while idle, applies Up/Down presses to the
//          selected BCD field of the group chosen by edit_mode, and hands the
//          finished group to the RTC write path with a req/ack handshake.
// Ports:   clk, reset (sync, active-high)
//          edit_mode (in 2), edit_pos (in 2): group and field selection
//          btn_up, btn_down (in 1): debounced level buttons, stepped on rising edge
//          rtc_valid (in 1), rtc_hora/rtc_fecha/rtc_timer (in 24): RTC read path
//          wr_ack (in 1): write accepted
//          hora_out/fecha_out/timer_out (out 24): current BCD {f0,f1,f2}
//          wr_req/wr_sel/wr_data (out): pending write, stable until ack
//          editing (out 1): high while in EDIT
module editor_valores
   import editor_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic [1:0]  edit_mode,
   input  logic [1:0]  edit_pos,
   input  logic        btn_up,
   input  logic        btn_down,
   input  logic        rtc_valid,
   input  logic [23:0] rtc_hora,
   input  logic [23:0] rtc_fecha,
   input  logic [23:0] rtc_timer,
   input  logic        wr_ack,
   output logic [23:0] hora_out,
   output logic [23:0] fecha_out,
   output logic [23:0] timer_out,
   output logic        wr_req,
   output logic [1:0]  wr_sel,
   output logic [23:0] wr_data,
   output logic        editing
);

   state_t      state, state_next;
   logic [1:0]  edit_sel;
   logic [23:0] hora_q, fecha_q, timer_q;
   logic [1:0]  wr_sel_q;
   logic [23:0] wr_data_q;
   logic        up_prev, down_prev;

   logic        load_rtc, latch_sel, do_step, start_commit;
   logic        up_rise, down_rise;
   logic [23:0] cur_group, stepped_group;
   logic [7:0]  cur_field, step_out;

   assign up_rise   = btn_up & ~up_prev;
   assign down_rise = btn_down & ~down_prev;

   always_comb begin
      cur_group = hora_q;
      case (edit_sel)
         MODE_TIMER: cur_group = timer_q;
         MODE_FECHA: cur_group = fecha_q;
         default:    cur_group = hora_q;
      endcase
   end

   always_comb begin
      cur_field = 8'h00;
      case (edit_pos)
         POS_F0:  cur_field = cur_group[23:16];
         POS_F1:  cur_field = cur_group[15:8];
         POS_F2:  cur_field = cur_group[7:0];
         default: cur_field = 8'h00;
      endcase
   end

   // One stepper shared by all groups; limits follow the latched mode.
   bcd_step u_step (
      .value   (cur_field),
      .min_val (field_min(edit_sel, edit_pos)),
      .max_val (field_max(edit_sel, edit_pos)),
      .inc     (up_rise),
      .dec     (down_rise),
      .result  (step_out)
   );

   always_comb begin
      stepped_group = cur_group;
      case (edit_pos)
         POS_F0:  stepped_group = {step_out, cur_group[15:0]};
         POS_F1:  stepped_group = {cur_group[23:16], step_out, cur_group[7:0]};
         POS_F2:  stepped_group = {cur_group[23:8], step_out};
         default: stepped_group = cur_group;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset)
         state <= ST_IDLE;
      else
         state <= state_next;
   end

   always_comb begin
      state_next   = state;
      load_rtc     = 1'b0;
      latch_sel    = 1'b0;
      do_step      = 1'b0;
      start_commit = 1'b0;
      case (state)
         ST_IDLE: begin
            load_rtc = rtc_valid;
            if (edit_mode != MODE_NONE) begin
               latch_sel  = 1'b1;
               state_next = ST_EDIT;
            end
         end
         ST_EDIT: begin
            // Leaving to 00 or switching to another group both commit the
            // group being edited; a new group is entered through IDLE.
            if (edit_mode != edit_sel) begin
               start_commit = 1'b1;
               state_next   = ST_COMMIT;
            end else if (edit_pos != POS_NONE && (up_rise ^ down_rise)) begin
               do_step = 1'b1;
            end
         end
         ST_COMMIT: begin
            if (wr_ack)
               state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         hora_q    <= HORA_RESET;
         fecha_q   <= FECHA_RESET;
         timer_q   <= TIMER_RESET;
         edit_sel  <= MODE_NONE;
         wr_sel_q  <= MODE_NONE;
         wr_data_q <= 24'h000000;
         up_prev   <= 1'b0;
         down_prev <= 1'b0;
      end else begin
         // History tracks buttons in every state so a held button never steps on entry.
         up_prev   <= btn_up;
         down_prev <= btn_down;
         if (load_rtc) begin
            hora_q  <= rtc_hora;
            fecha_q <= rtc_fecha;
            timer_q <= rtc_timer;
         end
         if (latch_sel)
            edit_sel <= edit_mode;
         if (do_step) begin
            case (edit_sel)
               MODE_TIMER: timer_q <= stepped_group;
               MODE_FECHA: fecha_q <= stepped_group;
               default:    hora_q  <= stepped_group;
            endcase
         end
         if (start_commit) begin
            wr_sel_q  <= edit_sel;
            wr_data_q <= cur_group;
         end
      end
   end

   assign hora_out  = hora_q;
   assign fecha_out = fecha_q;
   assign timer_out = timer_q;
   assign wr_req    = (state == ST_COMMIT);
   assign wr_sel    = wr_sel_q;
   assign wr_data   = wr_data_q;
   assign editing   = (state == ST_EDIT);

endmodule

// File: tb/tb_editor_valores.sv
// tb/tb_editor_valores.sv - directed scoreboard bench for editor_valores
module tb_editor_valores;

   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  edit_mode, edit_pos;
   logic        btn_up, btn_down, rtc_valid, wr_ack;
   logic [23:0] rtc_hora, rtc_fecha, rtc_timer;
   logic [23:0] hora_out, fecha_out, timer_out, wr_data;
   logic        wr_req, editing;
   logic [1:0]  wr_sel;

   int          checks = 0;
   int          errors = 0;
   logic [23:0] exp_q[$];
   string       tag_q[$];

   always #5 clk = ~clk;

   editor_valores dut (
      .clk       (clk),
      .reset     (reset),
      .edit_mode (edit_mode),
      .edit_pos  (edit_pos),
      .btn_up    (btn_up),
      .btn_down  (btn_down),
      .rtc_valid (rtc_valid),
      .rtc_hora  (rtc_hora),
      .rtc_fecha (rtc_fecha),
      .rtc_timer (rtc_timer),
      .wr_ack    (wr_ack),
      .hora_out  (hora_out),
      .fecha_out (fecha_out),
      .timer_out (timer_out),
      .wr_req    (wr_req),
      .wr_sel    (wr_sel),
      .wr_data   (wr_data),
      .editing   (editing)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_val(input string tag, input logic [23:0] val);
      exp_q.push_back(val);
      tag_q.push_back(tag);
   endtask

   task automatic chk(input logic [23:0] obs);
      logic [23:0] e;
      string       t;
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $error("FAIL scoreboard_empty observed=%h expected=<none>", obs);
      end else begin
         e = exp_q.pop_front();
         t = tag_q.pop_front();
         assert (obs === e) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", t, obs, e);
         end
      end
   endtask

   initial begin
      reset = 1'b1; edit_mode = 2'b00; edit_pos = 2'b00;
      btn_up = 1'b0; btn_down = 1'b0; rtc_valid = 1'b0; wr_ack = 1'b0;
      rtc_hora = 24'h0; rtc_fecha = 24'h0; rtc_timer = 24'h0;
      tick(); tick();
      reset = 1'b0;

      // reset state
      expect_val("rst_hora", 24'h000000);  chk(hora_out);
      expect_val("rst_fecha", 24'h010100); chk(fecha_out);
      expect_val("rst_timer", 24'h000000); chk(timer_out);
      expect_val("rst_wr_req", 24'h0);     chk({23'b0, wr_req});
      expect_val("rst_editing", 24'h0);    chk({23'b0, editing});

      // RTC mirror in IDLE
      rtc_valid = 1'b1; rtc_hora = 24'h235958; rtc_fecha = 24'h311299; rtc_timer = 24'h000000;
      tick(); rtc_valid = 1'b0;
      expect_val("load_hora", 24'h235958);  chk(hora_out);
      expect_val("load_fecha", 24'h311299); chk(fecha_out);

      // hora hh wrap up and down
      edit_mode = 2'b11; edit_pos = 2'b01;
      tick();
      expect_val("edit_enter", 24'h1); chk({23'b0, editing});
      btn_up = 1'b1; tick(); btn_up = 1'b0;
      expect_val("hora_hh_up_wrap", 24'h005958); chk(hora_out);
      tick();
      btn_down = 1'b1; tick(); btn_down = 1'b0;
      expect_val("hora_hh_dn_wrap", 24'h235958); chk(hora_out);
      tick();
      edit_mode = 2'b00; tick();
      expect_val("hora_wr_req", 24'h1);      chk({23'b0, wr_req});
      expect_val("hora_wr_sel", 24'h3);      chk({22'b0, wr_sel});
      expect_val("hora_wr_data", 24'h235958); chk(wr_data);
      expect_val("hora_editing_low", 24'h0); chk({23'b0, editing});
      wr_ack = 1'b1; tick(); wr_ack = 1'b0;
      expect_val("hora_ack_drop", 24'h0); chk({23'b0, wr_req});

      // fecha month wrap up, day wrap both ways, simultaneous presses
      edit_mode = 2'b10; edit_pos = 2'b10; tick();
      btn_up = 1'b1; tick(); btn_up = 1'b0;
      expect_val("mes_up_wrap", 24'h310199); chk(fecha_out);
      edit_pos = 2'b01; tick();
      btn_up = 1'b1; tick(); btn_up = 1'b0;
      expect_val("dia_up_wrap", 24'h010199); chk(fecha_out);
      tick();
      btn_down = 1'b1; tick(); btn_down = 1'b0;
      expect_val("dia_dn_wrap", 24'h310199); chk(fecha_out);
      tick();
      btn_up = 1'b1; btn_down = 1'b1; tick(); btn_up = 1'b0; btn_down = 1'b0;
      expect_val("both_rise", 24'h310199); chk(fecha_out);
      tick();
      edit_mode = 2'b00; tick();
      expect_val("fecha_wr_data", 24'h310199); chk(wr_data);
      wr_ack = 1'b1; tick(); wr_ack = 1'b0;

      // timer: held button on entry, ss down wrap, rtc_valid ignored, slow ack
      btn_up = 1'b1; edit_mode = 2'b01; edit_pos = 2'b11;
      tick(); tick();
      expect_val("held_no_step", 24'h000000); chk(timer_out);
      btn_up = 1'b0; tick();
      btn_down = 1'b1; tick(); btn_down = 1'b0;
      expect_val("timer_ss_dn_wrap", 24'h000059); chk(timer_out);
      rtc_valid = 1'b1; rtc_timer = 24'h121212; tick(); rtc_valid = 1'b0;
      expect_val("rtc_ignored_edit", 24'h000059); chk(timer_out);
      edit_mode = 2'b00; tick();
      expect_val("timer_wr_req", 24'h1);      chk({23'b0, wr_req});
      expect_val("timer_wr_sel", 24'h1);      chk({22'b0, wr_sel});
      expect_val("timer_wr_data", 24'h000059); chk(wr_data);
      for (int i = 0; i < 5; i++) tick();
      expect_val("req_held_no_ack", 24'h1); chk({23'b0, wr_req});
      wr_ack = 1'b1; tick(); wr_ack = 1'b0;
      expect_val("timer_ack_drop", 24'h0); chk({23'b0, wr_req});
      expect_val("timer_idle", 24'h0);     chk({23'b0, editing});

      // mode switch commits old group, then reset during COMMIT
      edit_mode = 2'b11; edit_pos = 2'b11; tick();
      btn_up = 1'b1; tick(); btn_up = 1'b0;
      expect_val("hora_ss_up", 24'h235959); chk(hora_out);
      edit_mode = 2'b10; tick();
      expect_val("switch_wr_req", 24'h1);      chk({23'b0, wr_req});
      expect_val("switch_wr_sel", 24'h3);      chk({22'b0, wr_sel});
      expect_val("switch_wr_data", 24'h235959); chk(wr_data);
      reset = 1'b1; edit_mode = 2'b00; tick(); reset = 1'b0;
      expect_val("rstc_wr_req", 24'h0);     chk({23'b0, wr_req});
      expect_val("rstc_hora", 24'h000000);  chk(hora_out);
      expect_val("rstc_fecha", 24'h010100); chk(fecha_out);
      expect_val("rstc_timer", 24'h000000); chk(timer_out);
      expect_val("rstc_wr_sel", 24'h0);     chk({22'b0, wr_sel});
      expect_val("rstc_wr_data", 24'h0);    chk(wr_data);

      // ack while idle is ignored
      wr_ack = 1'b1; tick(); tick(); wr_ack = 1'b0;
      expect_val("idle_ack_ignored", 24'h0); chk({23'b0, wr_req});

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
